// File: rtl/jt053246_drq.sv
// Draw-request queue between the 053246 object scanner and the line-buffer drawer.
// A small FIFO hands out one command at a time over a start/busy handshake and is flushed at each line start.
module jt053246_drq #(
  parameter int DW = 56,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          hs,
  input  logic          in_start,
  input  logic [DW-1:0] in_data,
  output logic          in_busy,
  output logic          dr_start,
  output logic [DW-1:0] dr_data,
  input  logic          dr_busy,
  output logic [AW:0]   level,
  output logic [AW:0]   peak,
  output logic [7:0]    drops
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level_nxt;
  logic [8:0]    drop_inc;
  logic          hs_l, flush, full, push, drop_in, issue;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 10'd255) ? 8'hff : s[7:0];
  endfunction

  assign flush   = hs & ~hs_l;
  assign full    = (level == DEPTH);
  assign in_busy = full | flush;
  assign push    = in_start & ~in_busy;
  assign drop_in = in_start & in_busy;

  // A flush discards the whole queue plus any push attempted in the same cycle
  assign drop_inc  = flush ? 9'(level) + 9'(drop_in) : 9'(drop_in);
  assign level_nxt = flush ? '0 : level + (AW+1)'(push) - (AW+1)'(issue);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: if (level != '0 && !flush) begin
        issue     = 1'b1;
        state_nxt = ACK;
      end
      ACK:  state_nxt = WAIT;
      WAIT: if (!dr_busy) begin
        if (level != '0 && !flush) begin
          issue     = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cen && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hs_l     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      peak     <= '0;
      drops    <= '0;
      dr_start <= 1'b0;
      dr_data  <= '0;
    end else if (cen) begin
      hs_l     <= hs;
      state    <= state_nxt;
      dr_start <= issue;
      if (issue) dr_data <= mem[rd_ptr];
      level    <= level_nxt;
      peak     <= flush ? '0 : ((level_nxt > peak) ? level_nxt : peak);
      drops    <= sat_add8(drops, drop_inc);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt053246_drq.sv
// Directed bench for jt053246_drq: latency, full/refuse, ordered drain, line flush, saturation, async reset.
module tb_jt053246_drq;
  localparam int DW = 56;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, cen, hs, in_start, dr_busy;
  logic [DW-1:0] in_data, dr_data;
  logic          in_busy, dr_start;
  logic [AW:0]   level, peak;
  logic [7:0]    drops;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  jt053246_drq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .hs(hs),
    .in_start(in_start), .in_data(in_data), .in_busy(in_busy),
    .dr_start(dr_start), .dr_data(dr_data), .dr_busy(dr_busy),
    .level(level), .peak(peak), .drops(drops)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] pl(input logic [15:0] code);
    return {code[7:0], 16'hbeef, code, code};
  endfunction

  task automatic push(input logic [15:0] code);
    in_start = 1'b1;
    in_data  = pl(code);
    tick();
    in_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   extra, last, found;
    rst = 1'b1; cen = 1'b1; hs = 1'b0; in_start = 1'b0; in_data = '0; dr_busy = 1'b0;
    tick(); tick();
    check("rst_start", dr_start, 0);
    check("rst_data",  dr_data,  0);
    check("rst_busy",  in_busy,  0);
    check("rst_level", level,    0);
    check("rst_peak",  peak,     0);
    check("rst_drops", drops,    0);
    rst = 1'b0;
    tick();

    // single command: dr_start one cen-cycle after the push
    push(16'h1234);
    check("lat_level",   level,    1);
    check("lat_nostart", dr_start, 0);
    tick();
    check("single_start", dr_start, 1);
    check("single_data",  dr_data,  pl(16'h1234));
    check("single_level", level,    0);
    cen = 1'b0;
    tick(); tick();
    check("cen_hold_start", dr_start, 1);
    cen = 1'b1;
    tick();
    check("pulse_end", dr_start, 0);
    tick(); tick();

    // fill while drawer stuck busy
    dr_busy = 1'b1;
    push(16'h0001);
    tick();
    check("busy_issue", dr_data, pl(16'h0001));
    tick();
    for (int i = 0; i < 4; i++) push(16'h0a00 + 16'(i));
    check("full_busy",  in_busy, 1);
    check("full_level", level,   4);
    push(16'h0a04);
    check("refuse_level", level, 4);
    check("refuse_drops", drops, 1);
    check("refuse_peak",  peak,  4);

    // drain in push order with an 8-cycle busy drawer
    extra = 0;
    last  = -100;
    for (int k = 0; k < 4; k++) begin
      dr_busy = 1'b0;
      found   = 0;
      for (int t = 0; t < 12 && found == 0; t++) begin
        tick();
        if (dr_start) found = 1;
      end
      check("drain_found", found, 1);
      check("drain_data",  dr_data, pl(16'h0a00 + 16'(k)));
      check("drain_gap",   (cyc - last) >= 2, 1);
      last    = cyc;
      dr_busy = 1'b1;
      repeat (8) begin
        tick();
        if (dr_start) extra++;
      end
    end
    dr_busy = 1'b0;
    tick(); tick();
    check("drain_extra", extra, 0);
    check("drain_level", level, 0);

    // line flush with one in flight, two queued and a push in the same cycle
    dr_busy = 1'b1;
    push(16'h00f0);
    tick();
    push(16'h00f1);
    push(16'h00f2);
    check("pre_flush_level", level, 2);
    hs = 1'b1; in_start = 1'b1; in_data = pl(16'h00ff);
    #1;
    check("flush_busy", in_busy, 1);
    tick();
    in_start = 1'b0;
    check("flush_level", level, 0);
    check("flush_drops", drops, 4);
    check("flush_peak",  peak,  0);
    extra = 0;
    repeat (3) begin tick(); if (dr_start) extra++; end
    dr_busy = 1'b0;
    hs      = 1'b0;
    repeat (10) begin tick(); if (dr_start) extra++; end
    check("flush_no_start", extra, 0);
    push(16'h0b0b);
    tick();
    check("post_flush_start", dr_start, 1);
    check("post_flush_data",  dr_data,  pl(16'h0b0b));
    tick(); tick();

    // saturation of drops while full
    dr_busy = 1'b1;
    push(16'h0c00);
    tick();
    for (int i = 1; i < 5; i++) push(16'h0c00 + 16'(i));
    in_start = 1'b1;
    in_data  = pl(16'h0cff);
    repeat (300) tick();
    check("sat_drops", drops, 255);
    check("sat_level", level, 4);
    check("sat_peak",  peak,  4);
    dr_busy = 1'b0;
    tick();
    check("nobypass_level", level,    3);
    check("nobypass_start", dr_start, 1);
    check("nobypass_drops", drops,    255);
    in_start = 1'b0;
    tick();
    in_start = 1'b1;
    in_data  = pl(16'h0c0c);
    tick();
    in_start = 1'b0;
    check("pushpop_level", level,    3);
    check("pushpop_start", dr_start, 1);

    // async reset while waiting with 3 queued
    dr_busy = 1'b1;
    tick();
    check("mid_wait_level", level, 3);
    rst = 1'b1;
    #1;
    check("arst_start", dr_start, 0);
    check("arst_data",  dr_data,  0);
    check("arst_level", level,    0);
    check("arst_peak",  peak,     0);
    check("arst_drops", drops,    0);
    check("arst_busy",  in_busy,  0);
    tick();
    rst     = 1'b0;
    dr_busy = 1'b0;
    extra   = 0;
    repeat (6) begin tick(); if (dr_start) extra++; end
    check("post_rst_no_start", extra, 0);
    check("post_rst_level",    level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
